eth_phy_10g_tx_gearbox: RTL and testbench
=========================================

Name: eth_phy_10g_tx_gearbox

Overview:
Transmit-side 66:64 gearbox for the 10G BASE-R PHY. It is the counterpart of the RX aligner.
- Accepts one 66-bit encoded block per cycle (2-bit sync header plus 64-bit payload) from the scrambler/encoder path.
- Packs blocks into a continuous 64-bit SERDES word stream.
- Pauses the upstream for one cycle in every 33.
- Sits between the TX 64b/66b encoder/scrambler and the SERDES TX parallel input inside eth_phy_10g_tx.

Parameters:
DATA_WIDTH, 64, payload width; only 64 supported, elaborate-time $error otherwise.
HDR_WIDTH, 2, sync header width; only 2 supported.
FRAME_WIDTH, DATA_WIDTH+HDR_WIDTH, block width.
SERDES_WIDTH, 64, SERDES parallel word width; only 64 supported.
BIT_REVERSE, 0, when 1, o_serdes_tx is bit-reversed within the 64-bit word.

Ports:
clk  input  1  TX clock; all logic on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_tx_data  input  64  block payload; bit 0 is sent first.
i_tx_hdr  input  2  sync header; bit 0 is sent first, ahead of the payload.
i_tx_valid  input  1  block present this cycle.
o_tx_ready  output  1  gearbox accepts a block this cycle.
o_serdes_tx  output  64  SERDES word; bit 0 is sent first.
o_tx_underrun  output  1  one-cycle pulse: ready was high but valid low, so an idle block was inserted.
o_tx_bad_hdr  output  1  one-cycle pulse: accepted header was 2'b00 or 2'b11.
o_gearbox_seq  output  6  current sequence count 0..32, for debug and test.

Behaviour:
- Reset is asynchronous on i_rst_n low; release is used synchronously.
- Reset values:
  - seq=0, residue=0, residue count=0
  - o_serdes_tx=64'h0, o_tx_underrun=0, o_tx_bad_hdr=0
  - o_tx_ready=1 after reset because seq=0.
- Sequence counter seq runs 0..32, increments every cycle, and wraps 32->0.
- o_tx_ready = (seq != 32). It is decoded from the registered seq, so there is no combinational path from i_tx_valid.
- Residue state: before cycle seq=s, the residue holds exactly 2*s valid bits in its LSBs (0 at s=0, 64 at s=32).
- When seq is 0..31:
  - The frame is F = {i_tx_data, i_tx_hdr} (66 bits, hdr in bits [1:0]).
  - If i_tx_valid=0, substitute the idle block: hdr=2'b10, data=64'h000000000000001E. Pulse o_tx_underrun next cycle.
  - Concatenate C = {F, residue[2s-1:0]}.
  - Next o_serdes_tx = C[63:0].
  - New residue = C[2s+65:64], which is 2s+2 bits.
- When seq is 32:
  - No block is accepted; i_tx_valid is ignored and there is no underrun pulse.
  - Next o_serdes_tx = residue[63:0].
  - Residue count becomes 0.
- Throughput is exactly 32 blocks per 33 cycles. Every cycle produces a valid SERDES word; the output never stalls.
- Latency: the block accepted at cycle N drives its first bits into o_serdes_tx at N+1. The tail of the block appears at N+2, except at s=31, where the tail appears in the seq=32 word at N+2.
- o_tx_bad_hdr:
  - Registered; asserted one cycle after acceptance of a header 00 or 11.
  - The block is still transmitted unchanged, with no substitution.
  - A substituted idle block never flags.
- BIT_REVERSE=1 reverses the bits of the registered output only; internal packing is unchanged.
- Reset mid-stream: the partial residue is discarded, the output returns to 0, and the next post-reset block starts at seq=0. No recovery of the lost block is attempted.
- The residue register is 64 bits wide. The shift/select uses a 2*s index, which is a constant-step mux; a variable-width multiplier is not permitted.

Decomposition:
Shared package eth_phy_10g_pkg holds:
- sync header constants SYNC_DATA=2'b01 and SYNC_CTRL=2'b10
- IDLE_BLOCK_DATA=64'h1E
- GEARBOX_SEQ_MAX=32
These are also reused by the RX aligner and decoder.

No sub-module: a single flat module of about 150-200 lines, instantiated by eth_phy_10g_tx alongside xgmii_baser_enc_64 and the TX scrambler.

Test Plan:
1. Reset, then a continuous stream of 32 valid blocks, each with hdr=01 and data = block index. Over 33 cycles the concatenated o_serdes_tx equals the concatenation of the 32 frames bit-exact. o_tx_ready is low only at seq=32 and o_tx_underrun stays 0.
2. Feed the output to an RX-aligner model with no bitslip. It locks, and the recovered hdr/data sequence matches the input, with no drops or duplicates over 1000 blocks.
3. Deassert i_tx_valid for 3 cycles at seq=5..7. Exactly 3 idle blocks (hdr=10, data=64'h1E) appear in the recovered stream and o_tx_underrun pulses 3 times. With valid low at seq=32, no pulse occurs.
4. Send hdr=2'b11 at seq=10. o_tx_bad_hdr pulses once one cycle later and the block is transmitted unchanged.
5. Assert i_rst_n low mid-stream at seq=17. Outputs go to 0 immediately (asynchronously); after release, o_gearbox_seq=0, o_tx_ready=1, and the first block's hdr appears in o_serdes_tx[1:0] on the following cycle.
6. With BIT_REVERSE=1, repeat scenario 1. Each output word equals the bit-reverse of the scenario 1 word.

Source files
------------

// File: rtl/eth_phy_10g_pkg.sv
// Shared 10G BASE-R PHY constants: sync headers, idle block, gearbox period.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package eth_phy_10g_pkg;

  // 64b/66b sync headers, transmitted bit 0 first.
  localparam logic [1:0]  SYNC_DATA = 2'b01;
  localparam logic [1:0]  SYNC_CTRL = 2'b10;

  // Payload of an all-idle control block (block type 0x1E, idle chars zero).
  localparam logic [63:0] IDLE_BLOCK_DATA = 64'h0000_0000_0000_001E;

  // The 66:64 gearbox repeats every GEARBOX_SEQ_MAX+1 cycles; the last
  // sequence slot only drains the residue and accepts no block.
  localparam int          GEARBOX_SEQ_MAX = 32;

  // Headers 00 and 11 are not legal 64b/66b sync patterns.
  function automatic logic is_bad_hdr(input logic [1:0] hdr);
    return (hdr == 2'b00) || (hdr == 2'b11);
  endfunction

  function automatic logic [63:0] bit_reverse64(input logic [63:0] word);
    logic [63:0] rev;
    rev = '0;
    for (int i = 0; i < 64; i++) begin
      rev[i] = word[63-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/eth_phy_10g_tx_gearbox.sv
// TX 66:64 gearbox: packs one 66-bit block per cycle into a continuous 64-bit SERDES stream.
// Latency: a block accepted at cycle N shows its first bits on o_serdes_tx at N+1, its tail at N+2.
// Backpressure: o_tx_ready drops for one cycle in 33 (seq=32); missing blocks become idle, output never stalls.
//
// Ports:
//   clk, i_rst_n                      TX clock, async active-low reset
//   i_tx_data/i_tx_hdr/i_tx_valid     66-bit block in (hdr in the two LSBs, bit 0 sent first)
//   o_tx_ready                        block accepted this cycle (registered-seq decode only)
//   o_serdes_tx                       64-bit SERDES word, bit 0 sent first
//   o_tx_underrun, o_tx_bad_hdr       one-cycle status pulses
//   o_gearbox_seq                     sequence count 0..32
module eth_phy_10g_tx_gearbox
  import eth_phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int HDR_WIDTH    = 2,
  parameter int FRAME_WIDTH  = DATA_WIDTH + HDR_WIDTH,
  parameter int SERDES_WIDTH = 64,
  parameter int BIT_REVERSE  = 0
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   i_tx_data,
  input  logic [HDR_WIDTH-1:0]    i_tx_hdr,
  input  logic                    i_tx_valid,
  output logic                    o_tx_ready,
  output logic [SERDES_WIDTH-1:0] o_serdes_tx,
  output logic                    o_tx_underrun,
  output logic                    o_tx_bad_hdr,
  output logic [5:0]              o_gearbox_seq
);

  if (DATA_WIDTH != 64 || HDR_WIDTH != 2 || SERDES_WIDTH != 64 || FRAME_WIDTH != 66) begin : g_bad_param
    $error("eth_phy_10g_tx_gearbox: only DATA_WIDTH=64, HDR_WIDTH=2, SERDES_WIDTH=64 are supported");
  end

  localparam logic [5:0] SEQ_LAST = 6'(GEARBOX_SEQ_MAX);

  // Registered state. The residue count is implicitly 2*seq, so no separate
  // counter is kept; residue bits above that count are always zero.
  logic [5:0]              seq;
  logic [SERDES_WIDTH-1:0] residue;
  logic [SERDES_WIDTH-1:0] word_q;
  logic                    underrun_q;
  logic                    bad_hdr_q;

  // Next-state values.
  logic [5:0]              seq_nxt;
  logic [SERDES_WIDTH-1:0] residue_nxt;
  logic [SERDES_WIDTH-1:0] word_nxt;
  logic                    underrun_nxt;
  logic                    bad_hdr_nxt;

  // Packing datapath.
  logic                    seq_last;
  logic [FRAME_WIDTH-1:0]  frame;
  logic [5:0]              shift_lo;
  logic [5:0]              shift_dn;
  logic [SERDES_WIDTH-1:0] low_mask;
  logic [SERDES_WIDTH-1:0] pack_word;

  always_comb begin
    seq_last = (seq == SEQ_LAST);

    frame = {i_tx_data, i_tx_hdr};
    if (!i_tx_valid) begin
      frame = {IDLE_BLOCK_DATA, SYNC_CTRL};
    end

    // In slots 0..31 the residue holds 2*s bits. seq[5] is only set in the
    // drain slot, which bypasses this path, so seq[4:0] is enough here and
    // the shift amount is a plain wire concatenation (even steps only).
    shift_lo = {seq[4:0], 1'b0};
    low_mask = ~({SERDES_WIDTH{1'b1}} << shift_lo);

    // Word = residue in the low 2s bits, frame bits filling the rest.
    pack_word = (residue & low_mask) | (frame[SERDES_WIDTH-1:0] << shift_lo);

    // Leftover frame bits are F[65:64-2s], i.e. payload bits [63:62-2s]:
    // shifting the 64-bit payload right by 62-2s keeps everything 64 wide.
    shift_dn    = 6'd62 - shift_lo;
    residue_nxt = frame[FRAME_WIDTH-1:HDR_WIDTH] >> shift_dn;

    seq_nxt      = seq + 6'd1;
    word_nxt     = pack_word;
    underrun_nxt = !i_tx_valid;
    bad_hdr_nxt  = i_tx_valid && is_bad_hdr(i_tx_hdr);

    // Drain slot: flush the full 64-bit residue, take nothing from upstream.
    if (seq_last) begin
      seq_nxt      = '0;
      word_nxt     = residue;
      residue_nxt  = '0;
      underrun_nxt = 1'b0;
      bad_hdr_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seq        <= '0;
      residue    <= '0;
      word_q     <= '0;
      underrun_q <= 1'b0;
      bad_hdr_q  <= 1'b0;
    end else begin
      seq        <= seq_nxt;
      residue    <= residue_nxt;
      word_q     <= word_nxt;
      underrun_q <= underrun_nxt;
      bad_hdr_q  <= bad_hdr_nxt;
    end
  end

  // Ready depends only on registered seq: no path from i_tx_valid.
  assign o_tx_ready    = (seq != SEQ_LAST);
  assign o_tx_underrun = underrun_q;
  assign o_tx_bad_hdr  = bad_hdr_q;
  assign o_gearbox_seq = seq;

  // Reversal is pure wiring on the registered word; packing is unaffected.
  if (BIT_REVERSE != 0) begin : g_rev
    assign o_serdes_tx = bit_reverse64(word_q);
  end else begin : g_fwd
    assign o_serdes_tx = word_q;
  end

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
module tb_eth_phy_10g_tx_gearbox;
  import eth_phy_10g_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] tx_data;
  logic [1:0]  tx_hdr;
  logic        tx_valid;

  logic        ready, ready_r;
  logic [63:0] serdes, serdes_r;
  logic        under, under_r;
  logic        bad, bad_r;
  logic [5:0]  seqo, seqo_r;

  always #5 clk = ~clk;

  eth_phy_10g_tx_gearbox #(.BIT_REVERSE(0)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_hdr(tx_hdr),
    .i_tx_valid(tx_valid), .o_tx_ready(ready), .o_serdes_tx(serdes),
    .o_tx_underrun(under), .o_tx_bad_hdr(bad), .o_gearbox_seq(seqo)
  );

  eth_phy_10g_tx_gearbox #(.BIT_REVERSE(1)) dut_rev (
    .clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_hdr(tx_hdr),
    .i_tx_valid(tx_valid), .o_tx_ready(ready_r), .o_serdes_tx(serdes_r),
    .o_tx_underrun(under_r), .o_tx_bad_hdr(bad_r), .o_gearbox_seq(seqo_r)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a serial bit stream. Each accepted slot appends 66 bits,
  // each cycle removes 64; the slot counter only decides whether a block is taken.
  bit          mq[$];
  int          pos;
  logic [63:0] exp_word;
  logic        exp_under, exp_bad;

  // Receive side: recover 66-bit frames from the DUT output, no bitslip.
  logic [65:0] sent[$];
  bit          rxq[$];
  int          rx_frames, rx_idle, under_cnt, bad_cnt;

  typedef struct {
    logic        v;
    logic [1:0]  h;
    logic [63:0] d;
    logic [63:0] e_word;
    logic        e_under;
    logic        e_bad;
    logic [5:0]  e_seq;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [63:0] rev64(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = w[63-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rxq.delete();
    sent.delete();
    pos       = 0;
    exp_word  = '0;
    exp_under = 1'b0;
    exp_bad   = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_serdes"},   serdes,   64'h0);
    chk({tag, "_serdes_r"}, serdes_r, 64'h0);
    chk({tag, "_underrun"}, under,    1'b0);
    chk({tag, "_bad_hdr"},  bad,      1'b0);
    chk({tag, "_seq"},      seqo,     6'd0);
    chk({tag, "_ready"},    ready,    1'b1);
  endtask

  // One clock: check pre-edge decode, update model, apply edge, check outputs.
  task automatic cycle(input logic v, input logic [1:0] h, input logic [63:0] d);
    logic [65:0] f;
    logic [65:0] rf;
    chk("ready",   ready,   (pos != 32));
    chk("ready_r", ready_r, (pos != 32));
    chk("seq",     seqo,    pos);
    chk("seq_r",   seqo_r,  pos);
    if (pos != 32) begin
      f = v ? {d, h} : {IDLE_BLOCK_DATA, SYNC_CTRL};
      for (int i = 0; i < 66; i++) mq.push_back(f[i]);
      sent.push_back(f);
      exp_under = !v;
      exp_bad   = v && (h == 2'b00 || h == 2'b11);
    end else begin
      exp_under = 1'b0;
      exp_bad   = 1'b0;
    end
    for (int i = 0; i < 64; i++) exp_word[i] = mq.pop_front();
    pos = (pos + 1) % 33;

    tx_valid = v;
    tx_hdr   = h;
    tx_data  = d;
    @(posedge clk);
    #1;
    chk("serdes",     serdes,   exp_word);
    chk("serdes_rev", serdes_r, rev64(exp_word));
    chk("underrun",   under,    exp_under);
    chk("underrun_r", under_r,  exp_under);
    chk("bad_hdr",    bad,      exp_bad);
    chk("bad_hdr_r",  bad_r,    exp_bad);
    if (under) under_cnt++;
    if (bad) bad_cnt++;

    for (int i = 0; i < 64; i++) rxq.push_back(serdes[i]);
    while (rxq.size() >= 66) begin
      for (int i = 0; i < 66; i++) rf[i] = rxq.pop_front();
      rx_frames++;
      if (rf == {IDLE_BLOCK_DATA, SYNC_CTRL}) rx_idle++;
      n_chk++;
      if (sent.size() == 0) begin
        n_fail++;
        $display("FAIL rx_extra: recovered frame %h with nothing pending", rf);
      end else begin
        n_chk--;
        chk("rx_frame", rf, sent.pop_front());
      end
    end
  endtask

  task automatic rand_cycle();
    logic        v;
    logic [1:0]  h;
    int          r;
    v = ($urandom_range(0, 9) != 0);
    r = $urandom_range(0, 15);
    if (r == 0)      h = 2'b00;
    else if (r == 1) h = 2'b11;
    else             h = r[0] ? SYNC_DATA : SYNC_CTRL;
    cycle(v, h, {$urandom, $urandom});
  endtask

  task automatic run_to(input int target);
    while (pos != target) cycle(1'b1, SYNC_DATA, {$urandom, $urandom});
  endtask

  task automatic apply_reset();
    tx_valid = 1'b0;
    rst_n    = 1'b0;
    #7;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ub, ib, bb;

    // {valid, hdr, data} -> {word, underrun, bad_hdr, seq} right after the edge.
    tbl[0] = '{1'b1, 2'b01, 64'h0000_0000_0000_000A, 64'h0000_0000_0000_0029, 1'b0, 1'b0, 6'd1};
    tbl[1] = '{1'b0, 2'b01, 64'h0000_0000_0000_5555, 64'h0000_0000_0000_01E8, 1'b1, 1'b0, 6'd2};
    tbl[2] = '{1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b1, 6'd3};
    tbl[3] = '{1'b1, 2'b00, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_003F, 1'b0, 1'b1, 6'd4};
    tbl[4] = '{1'b1, 2'b10, 64'h8000_0000_0000_0003, 64'h0000_0000_0000_0E00, 1'b0, 1'b0, 6'd5};
    tbl[5] = '{1'b1, 2'b01, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0600, 1'b0, 1'b0, 6'd6};

    rx_frames = 0; rx_idle = 0; under_cnt = 0; bad_cnt = 0;
    tx_valid = 1'b0; tx_hdr = 2'b00; tx_data = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Hand-computed packing vectors from reset.
    foreach (tbl[k]) begin
      cycle(tbl[k].v, tbl[k].h, tbl[k].d);
      chk($sformatf("tbl%0d_word", k),     serdes, tbl[k].e_word);
      chk($sformatf("tbl%0d_underrun", k), under,  tbl[k].e_under);
      chk($sformatf("tbl%0d_bad", k),      bad,    tbl[k].e_bad);
      chk($sformatf("tbl%0d_seq", k),      seqo,   tbl[k].e_seq);
    end

    // Full 33-cycle period of data blocks numbered 0..31.
    apply_reset();
    for (int i = 0; i < 33; i++) cycle(1'b1, SYNC_DATA, 64'(i));
    chk("period_flushed", mq.size(), 0);

    // Three underruns at seq 5..7, and valid low in the drain slot.
    run_to(5);
    ub = under_cnt;
    ib = rx_idle;
    for (int i = 0; i < 3; i++) cycle(1'b0, SYNC_DATA, 64'h0);
    run_to(32);
    cycle(1'b0, SYNC_DATA, 64'h0);
    run_to(3);
    chk("underrun_count", under_cnt - ub, 3);
    chk("idle_recovered", rx_idle - ib, 3);

    // Illegal header at seq 10: flagged once, block passes through as-is.
    run_to(10);
    bb = bad_cnt;
    cycle(1'b1, 2'b11, 64'hDEAD_BEEF_0123_4567);
    chk("bad_hdr_pulse", bad, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, SYNC_DATA, {$urandom, $urandom});
    chk("bad_hdr_count", bad_cnt - bb, 1);

    // Long random run through the receive-side model.
    ib = rx_frames;
    for (int i = 0; i < 1100; i++) rand_cycle();
    chk("rx_min_frames", (rx_frames - ib) >= 1000, 1'b1);
    chk("rx_pending_le1", sent.size() <= 1, 1'b1);

    // Asynchronous reset in the middle of a period.
    run_to(17);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    #2;
    rst_n = 1'b1;
    cycle(1'b1, SYNC_DATA, 64'h0123_4567_89AB_CDEF);
    chk("post_rst_hdr", serdes[1:0], SYNC_DATA);
    for (int i = 0; i < 70; i++) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
